// File: rtl/debug_uart_dumper.sv
// rtl/debug_uart_dumper.sv - snapshots PC/Instr/Regout on each PC change and prints them as an ASCII hex line over UART 8N1
module debug_uart_dumper #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic [31:0] iPC,
  input  logic [31:0] iInstr,
  input  logic [31:0] iRegout,
  input  logic        iEnable,
  output logic        oTX,
  output logic        oBusy,
  output logic [7:0]  oDropped
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  LAST_CHAR = 5'd27;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      state;
  logic [31:0] last_pc;
  logic        force_pend;
  logic [31:0] snap_pc;
  logic [31:0] snap_instr;
  logic [31:0] snap_regout;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [4:0]  char_idx;
  logic [7:0]  shreg;
  logic [7:0]  load_char;
  logic        trigger;

  function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] pos);
    logic [31:0] s;
    // pos 0 is the most significant nibble
    s = w >> (5'(3'd7 - pos) << 2);
    return s[3:0];
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n - 4'd10};
  endfunction

  assign trigger = ((iPC != last_pc) || force_pend) && iEnable;

  always_comb begin
    load_char = 8'h20;
    if (char_idx <= 5'd7)
      load_char = hex_ascii(nibble(snap_pc, char_idx[2:0]));
    else if (char_idx >= 5'd9 && char_idx <= 5'd16)
      load_char = hex_ascii(nibble(snap_instr, 3'(char_idx - 5'd9)));
    else if (char_idx >= 5'd18 && char_idx <= 5'd25)
      load_char = hex_ascii(nibble(snap_regout, 3'(char_idx - 5'd18)));
    else if (char_idx == 5'd26)
      load_char = 8'h0D;
    else if (char_idx == 5'd27)
      load_char = 8'h0A;
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state       <= S_IDLE;
      oTX         <= 1'b1;
      oBusy       <= 1'b0;
      oDropped    <= 8'h00;
      last_pc     <= 32'h0;
      force_pend  <= 1'b1;
      snap_pc     <= 32'h0;
      snap_instr  <= 32'h0;
      snap_regout <= 32'h0;
      bit_cnt     <= 16'h0;
      bit_idx     <= 3'd0;
      char_idx    <= 5'd0;
      shreg       <= 8'h00;
    end else begin
      last_pc <= iPC;

      // An IDLE check here (not oBusy) makes the final stop-bit cycle count as busy
      if (trigger) begin
        if (state == S_IDLE) begin
          snap_pc     <= iPC;
          snap_instr  <= iInstr;
          snap_regout <= iRegout;
          force_pend  <= 1'b0;
          oBusy       <= 1'b1;
          char_idx    <= 5'd0;
          state       <= S_LOAD;
        end else if (oDropped != 8'hFF) begin
          oDropped <= oDropped + 8'd1;
        end
      end

      case (state)
        S_IDLE: begin
        end
        S_LOAD: begin
          shreg   <= load_char;
          oTX     <= 1'b0;
          bit_cnt <= BIT_LAST;
          state   <= S_START;
        end
        S_START: begin
          if (bit_cnt == 16'h0) begin
            oTX     <= shreg[0];
            shreg   <= {1'b1, shreg[7:1]};
            bit_idx <= 3'd0;
            bit_cnt <= BIT_LAST;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_cnt == 16'h0) begin
            bit_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              oTX   <= 1'b1;
              state <= S_STOP;
            end else begin
              oTX     <= shreg[0];
              shreg   <= {1'b1, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_cnt == 16'h0) begin
            if (char_idx == LAST_CHAR) begin
              oBusy <= 1'b0;
              state <= S_IDLE;
            end else begin
              char_idx <= char_idx + 5'd1;
              state    <= S_LOAD;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_uart_dumper.sv
// tb/tb_debug_uart_dumper.sv - randomized bench for debug_uart_dumper against a queue-based waveform model
module tb_debug_uart_dumper;

  localparam int C = 4;

  logic        CLOCK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] iPC = 32'h0;
  logic [31:0] iInstr = 32'h0;
  logic [31:0] iRegout = 32'h0;
  logic        iEnable = 1'b0;
  logic        oTX;
  logic        oBusy;
  logic [7:0]  oDropped;

  debug_uart_dumper #(.CLKS_PER_BIT(C)) dut (
    .CLOCK   (CLOCK),
    .Reset   (Reset),
    .iPC     (iPC),
    .iInstr  (iInstr),
    .iRegout (iRegout),
    .iEnable (iEnable),
    .oTX     (oTX),
    .oBusy   (oBusy),
    .oDropped(oDropped)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string hex8(input logic [31:0] w);
    string hx = "0123456789ABCDEF";
    string s = "";
    for (int i = 7; i >= 0; i--) begin
      int n;
      n = int'(w[4*i +: 4]);
      s = {s, hx.substr(n, n)};
    end
    return s;
  endfunction

  function automatic string frame_text(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] rg);
    return {hex8(pc), " ", hex8(ins), " ", hex8(rg), "\r\n"};
  endfunction

  // Model: each accepted frame becomes a queue of per-cycle oTX levels; busy while it drains
  bit          m_q[$];
  logic [7:0]  m_drop = 8'h00;
  logic [31:0] m_last = 32'h0;
  bit          m_force = 1'b1;
  string       m_frame = "";
  bit          m_idle;
  bit          m_trig;
  logic [7:0]  m_ch;

  always @(posedge CLOCK) begin
    if (Reset) begin
      m_q.delete();
      m_drop  = 8'h00;
      m_last  = 32'h0;
      m_force = 1'b1;
    end else begin
      m_idle = (m_q.size() == 0);
      m_trig = ((iPC != m_last) || m_force) && iEnable;
      if (!m_idle) void'(m_q.pop_front());
      if (m_trig) begin
        if (m_idle) begin
          m_frame = frame_text(iPC, iInstr, iRegout);
          for (int k = 0; k < 28; k++) begin
            m_ch = m_frame[k];
            m_q.push_back(1'b1);
            repeat (C) m_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) repeat (C) m_q.push_back(m_ch[b]);
            repeat (C) m_q.push_back(1'b1);
          end
          m_force = 1'b0;
        end else if (m_drop != 8'hFF) begin
          m_drop = m_drop + 8'd1;
        end
      end
      m_last = iPC;
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge CLOCK) begin
    if (cmp_on) begin
      check("tx",      64'(oTX),      64'((m_q.size() != 0) ? m_q[0] : 1'b1));
      check("busy",    64'(oBusy),    64'(m_q.size() != 0));
      check("dropped", 64'(oDropped), 64'(m_drop));
    end
  end

  // UART receiver on the DUT pin; samples each bit one cycle past its first cycle
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  initial begin
    forever begin
      @(negedge CLOCK);
      if (oTX === 1'b0 && Reset === 1'b0) begin
        repeat (C + 1) @(negedge CLOCK);
        rx_b[0] = oTX;
        for (int b = 1; b < 8; b++) begin
          repeat (C) @(negedge CLOCK);
          rx_b[b] = oTX;
        end
        repeat (C) @(negedge CLOCK);
        rx_q.push_back(rx_b);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (oBusy !== 1'b0 && n < 3000) begin
      step(1);
      n++;
    end
    check({name, "_idle_timeout"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic check_rx(input string name, input string exp, input int len);
    check({name, "_rx_count"}, 64'(rx_q.size() >= len), 64'd1);
    for (int i = 0; i < len; i++)
      if (i < rx_q.size()) check($sformatf("%s_byte%0d", name, i), 64'(rx_q[i]), 64'(exp[i]));
  endtask

  logic [40:0] wave;
  int          lat;
  int          bad;
  logic [31:0] pc_tmp;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iPC = 32'h00400000; iInstr = 32'h00000013; iRegout = 32'h0; iEnable = 1'b1;
    Reset = 1'b1;
    @(posedge CLOCK);
    cmp_on = 1'b1;
    #2;
    check("reset_tx", 64'(oTX), 64'd1);
    check("reset_busy", 64'(oBusy), 64'd0);
    check("reset_dropped", 64'(oDropped), 64'd0);
    step(2);
    Reset = 1'b0;

    lat = 0;
    do begin
      @(posedge CLOCK);
      lat++;
      @(negedge CLOCK);
    end while (oTX !== 1'b0 && lat < 10);
    check("start_latency", 64'(lat), 64'd2);

    wave[0] = oTX;
    for (int i = 1; i < 41; i++) begin
      @(negedge CLOCK);
      wave[i] = oTX;
    end
    check("char0_wave", 64'(wave), 64'h1F00FF00000);

    step(1);
    iPC = 32'h00400004;
    step(1);
    wait_idle("frame1");
    check("frame1_dropped", 64'(oDropped), 64'd1);
    check_rx("frame1", "00400000 00000013 00000000\r\n", 28);

    bad = 0;
    repeat (2000) begin
      step(1);
      if (oTX !== 1'b1 || oBusy !== 1'b0) bad++;
    end
    check("quiet_2000", 64'(bad), 64'd0);

    iPC = iPC + 32'd4;
    for (int i = 0; i < 300; i++) begin
      step(1);
      iPC = iPC + 32'd4 * $urandom_range(1, 1000);
    end
    step(1);
    wait_idle("sat");
    check("dropped_saturated", 64'(oDropped), 64'hFF);

    iPC = $urandom; iInstr = $urandom; iRegout = $urandom;
    step(1);
    step(10 * (10 * C + 1) + 1 + 3 * C + 1);
    check("midframe_busy", 64'(oBusy), 64'd1);
    Reset = 1'b1;
    step(1);
    check("abort_tx", 64'(oTX), 64'd1);
    check("abort_busy", 64'(oBusy), 64'd0);
    check("abort_dropped", 64'(oDropped), 64'd0);
    step(59);
    rx_q.delete();
    Reset = 1'b0;
    step(2);
    check("forced_busy", 64'(oBusy), 64'd1);
    wait_idle("forced");
    check_rx("forced", frame_text(iPC, iInstr, iRegout), 28);

    iEnable = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      iPC = iPC + 32'h100;
      repeat (10) begin
        step(1);
        if (oTX !== 1'b1 || oBusy !== 1'b0) bad++;
      end
    end
    check("disabled_quiet", 64'(bad), 64'd0);
    check("disabled_dropped", 64'(oDropped), 64'd0);
    rx_q.delete();
    iPC = 32'hDEADBEEF; iEnable = 1'b1;
    step(3);
    wait_idle("deadbeef");
    check_rx("deadbeef", "DEADBEEF ", 9);

    for (int i = 0; i < 4000; i++) begin
      iInstr = $urandom;
      iRegout = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        pc_tmp = ($urandom_range(0, 3) == 0) ? iPC : $urandom;
        iPC = pc_tmp;
      end
      if ($urandom_range(0, 49) == 0) iEnable = ~iEnable;
      Reset = ($urandom_range(0, 1499) == 0);
      step(1);
    end
    Reset = 1'b0;
    iEnable = 1'b1;
    step(1);
    wait_idle("random");
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
